// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in/serial-out shifter producing a gapless serial
//               stream, one bit per clock, reloading every WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_out;

    logic             w_load;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_next_shreg;
    logic             w_next_bit;

    // Load and shift share one datapath: only the source word differs.
    assign w_load = (r_cnt == '0);
    assign w_src  = w_load ? in : r_shreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next_bit   = w_src[WIDTH-1];
            assign w_next_shreg = {w_src[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_next_bit   = w_src[0];
            assign w_next_shreg = {1'b0, w_src[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_out   <= w_next_bit;
            r_shreg <= w_next_shreg;
            r_cnt   <= w_load ? CW'(WIDTH - 1) : (r_cnt - CW'(1));
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_reg.sv
// ============================================================================
// Module      : tb_piso_shift_reg
// Description : Self-checking bench for piso_shift_reg (MSB/LSB, WIDTH 4/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in4 = '0;
    logic [7:0] in8 = '0;
    logic       out_m4;
    logic       out_l4;
    logic       out_m8;

    int checks = 0;
    int errors = 0;

    bit q_m4[$];
    bit q_l4[$];
    bit q_m8[$];
    bit e_m4, e_l4, e_m8;

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk(clk), .rst(rst), .in(in4), .out(out_m4));
    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk(clk), .rst(rst), .in(in4), .out(out_l4));
    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .rst(rst), .in(in8), .out(out_m8));

    typedef struct {
        bit         rst;
        logic [3:0] in4;
        logic [7:0] in8;
        bit         exp;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge, advance the reference queues, then compare all DUTs.
    task automatic apply(input bit r, input logic [3:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        in4 = a;
        in8 = b;
        @(posedge clk);
        if (r) begin
            q_m4.delete(); q_l4.delete(); q_m8.delete();
            e_m4 = 1'b0; e_l4 = 1'b0; e_m8 = 1'b0;
        end else begin
            if (q_m4.size() == 0) for (int i = 3; i >= 0; i--) q_m4.push_back(a[i]);
            if (q_l4.size() == 0) for (int i = 0; i < 4; i++)  q_l4.push_back(a[i]);
            if (q_m8.size() == 0) for (int i = 7; i >= 0; i--) q_m8.push_back(b[i]);
            e_m4 = q_m4.pop_front();
            e_l4 = q_l4.pop_front();
            e_m8 = q_m8.pop_front();
        end
        #1;
        chk("sb_msb4", out_m4, e_m4);
        chk("sb_lsb4", out_l4, e_l4);
        chk("sb_msb8", out_m8, e_m8);
    endtask

    vec_t tbl[$];
    logic [7:0] exp8;
    logic [3:0] expl;

    initial begin
        // reset hold with in toggling
        tbl.push_back('{1'b1, 4'b0011, 8'hFF, 1'b0});
        tbl.push_back('{1'b1, 4'b1010, 8'hFF, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 8'hFF, 1'b0});
        tbl.push_back('{1'b1, 4'b1011, 8'hFF, 1'b0});
        // single frame; in changes mid-frame are ignored
        tbl.push_back('{1'b0, 4'b0001, 8'h96, 1'b0});
        tbl.push_back('{1'b0, 4'b1101, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1101, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1101, 8'h00, 1'b1});
        // back-to-back frames
        tbl.push_back('{1'b0, 4'b0001, 8'h5A, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 4'b1001, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 4'b1001, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 8'h00, 1'b1});
        // reset after two bits of 1111
        tbl.push_back('{1'b0, 4'b1111, 8'hC3, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 8'hFF, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 8'h81, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1100, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 8'h00, 1'b0});

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].in4, tbl[i].in8);
            chk($sformatf("vec%0d_msb4", i), out_m4, tbl[i].exp);
        end

        // Fresh alignment: LSB-first 1100 and WIDTH=8 A5 then 3C 8 edges later.
        apply(1'b1, 4'b0000, 8'h00);
        expl = 4'b1100;
        exp8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 4'b1100, (k == 0) ? 8'hA5 : 8'h00);
            chk($sformatf("lsb4_bit%0d", k), out_l4, expl[k % 4]);
            chk($sformatf("w8_A5_bit%0d", k), out_m8, exp8[7 - k]);
        end
        exp8 = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 4'b1100, (k == 0) ? 8'h3C : 8'hFF);
            chk($sformatf("w8_3C_bit%0d", k), out_m8, exp8[7 - k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
